// File: rtl/fft_pkg.sv
// Shared types and width helpers for the FFT address-generation blocks.
// Widths are derived from LOG2N_MAX so every block agrees on bus sizes.
package fft_pkg;

  localparam int LOG2N_MAX_DEF = 5;

  typedef enum logic [1:0] {
    AGU_IDLE = 2'd0,
    AGU_RUN  = 2'd1,
    AGU_GAP  = 2'd2
  } agu_state_t;

  function automatic int addrWidth(input int log2nMax);
    return log2nMax;
  endfunction

  function automatic int stageWidth(input int log2nMax);
    return (log2nMax > 1) ? $clog2(log2nMax) : 1;
  endfunction

  // Twiddle ROM holds N_MAX/2 entries; the pair counter shares this width.
  function automatic int twiddleWidth(input int log2nMax);
    return (log2nMax > 1) ? log2nMax - 1 : 1;
  endfunction

  function automatic int nlog2Width(input int log2nMax);
    return $clog2(log2nMax + 1);
  endfunction

endpackage

// File: rtl/agu_addr_map.sv
// Combinational (stage, pair) -> operand and twiddle address mapping for an
// in-place radix-2 DIT butterfly; the parent registers the results.
module agu_addr_map
  import fft_pkg::*;
#(
  parameter int LOG2N_MAX = LOG2N_MAX_DEF
) (
  input  logic [stageWidth(LOG2N_MAX)-1:0]   stage_i,
  input  logic [twiddleWidth(LOG2N_MAX)-1:0] pair_i,
  output logic [addrWidth(LOG2N_MAX)-1:0]    address1_o,
  output logic [addrWidth(LOG2N_MAX)-1:0]    address2_o,
  output logic [twiddleWidth(LOG2N_MAX)-1:0] twiddle_o
);

  localparam int AW = addrWidth(LOG2N_MAX);
  localparam int SW = stageWidth(LOG2N_MAX);
  localparam int TW = twiddleWidth(LOG2N_MAX);

  logic [TW-1:0] posMask;
  logic [TW-1:0] pos;
  logic [TW-1:0] grp;

  // Split the pair index into position-within-group and group number, then
  // open a zero bit at position 'stage' to form the upper operand index.
  always_comb begin
    posMask    = (TW'(1) << stage_i) - TW'(1);
    pos        = pair_i & posMask;
    grp        = pair_i >> stage_i;
    address1_o = ((AW'(grp) << stage_i) << 1) | AW'(pos);
    address2_o = address1_o + (AW'(1) << stage_i);
    twiddle_o  = pos << (SW'(TW) - stage_i);
  end

endmodule

// File: rtl/fft_agu_seq.sv
// Self-sequencing radix-2 DIT FFT address generator: walks every stage and
// butterfly pair after one start, with valid/ready stalls and stage gaps.
module fft_agu_seq
  import fft_pkg::*;
#(
  parameter int LOG2N_MAX = LOG2N_MAX_DEF,
  parameter int STAGE_GAP = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [nlog2Width(LOG2N_MAX)-1:0]   n_log2,
  input  logic                               inverse,
  input  logic                               ready,
  output logic                               valid,
  output logic [addrWidth(LOG2N_MAX)-1:0]    address1,
  output logic [addrWidth(LOG2N_MAX)-1:0]    address2,
  output logic [twiddleWidth(LOG2N_MAX)-1:0] twiddle_address,
  output logic                               twiddle_conj,
  output logic [stageWidth(LOG2N_MAX)-1:0]   stage,
  output logic                               last_in_stage,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int AW = addrWidth(LOG2N_MAX);
  localparam int SW = stageWidth(LOG2N_MAX);
  localparam int TW = twiddleWidth(LOG2N_MAX);
  localparam int NW = nlog2Width(LOG2N_MAX);
  localparam int GW = 4;
  localparam logic [GW-1:0] GAP_LOAD = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  agu_state_t    state_q, state_d;
  logic [NW-1:0] nLog2_q, nLog2_d;
  logic          conj_q, conj_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [TW-1:0] pair_q, pair_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_d, err_d;

  logic [TW-1:0] lastPairCur, lastPairNext;
  logic [SW-1:0] lastStage;
  logic [AW-1:0] mapAddr1, mapAddr2;
  logic [TW-1:0] mapTwiddle;

  logic          valid_q, busy_q, done_q, err_q, last_q;
  logic [AW-1:0] addr1_q, addr2_q;
  logic [TW-1:0] twiddle_q;

  function automatic logic [TW-1:0] lastPairOf(input logic [NW-1:0] n);
    return (int'(n) > 0) ? TW'((1 << (int'(n) - 1)) - 1) : '0;
  endfunction

  assign lastPairCur  = lastPairOf(nLog2_q);
  assign lastPairNext = lastPairOf(nLog2_d);
  assign lastStage    = SW'(int'(nLog2_q) - 1);

  // Sequencer: a beat advances only on acceptance, so a stalled beat keeps
  // every next-state value equal to the current one.
  always_comb begin
    state_d = state_q;
    nLog2_d = nLog2_q;
    conj_d  = conj_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      AGU_IDLE: begin
        if (start) begin
          if (int'(n_log2) >= 1 && int'(n_log2) <= LOG2N_MAX) begin
            state_d = AGU_RUN;
            nLog2_d = n_log2;
            conj_d  = inverse;
            stage_d = '0;
            pair_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      AGU_RUN: begin
        if (ready) begin
          if (pair_q == lastPairCur) begin
            pair_d = '0;
            if (stage_q == lastStage) begin
              state_d = AGU_IDLE;
              done_d  = 1'b1;
            end else if (STAGE_GAP > 0) begin
              state_d = AGU_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              stage_d = stage_q + SW'(1);
            end
          end else begin
            pair_d = pair_q + TW'(1);
          end
        end
      end
      AGU_GAP: begin
        if (gap_q == '0) begin
          state_d = AGU_RUN;
          stage_d = stage_q + SW'(1);
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = AGU_IDLE;
    endcase
  end

  agu_addr_map #(
    .LOG2N_MAX(LOG2N_MAX)
  ) u_addr_map (
    .stage_i   (stage_d),
    .pair_i    (pair_d),
    .address1_o(mapAddr1),
    .address2_o(mapAddr2),
    .twiddle_o (mapTwiddle)
  );

  // Outputs are registered from next-state values so they line up with the
  // beat the state registers describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= AGU_IDLE;
      nLog2_q   <= '0;
      conj_q    <= 1'b0;
      stage_q   <= '0;
      pair_q    <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      twiddle_q <= '0;
    end else begin
      state_q   <= state_d;
      nLog2_q   <= nLog2_d;
      conj_q    <= conj_d;
      stage_q   <= stage_d;
      pair_q    <= pair_d;
      gap_q     <= gap_d;
      valid_q   <= (state_d == AGU_RUN);
      busy_q    <= (state_d != AGU_IDLE);
      done_q    <= done_d;
      err_q     <= err_d;
      last_q    <= (state_d == AGU_RUN) && (pair_d == lastPairNext);
      addr1_q   <= mapAddr1;
      addr2_q   <= mapAddr2;
      twiddle_q <= mapTwiddle;
    end
  end

  assign valid           = valid_q;
  assign address1        = addr1_q;
  assign address2        = addr2_q;
  assign twiddle_address = twiddle_q;
  assign twiddle_conj    = conj_q;
  assign stage           = stage_q;
  assign last_in_stage   = last_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_fft_agu_seq.sv
// Scoreboard bench for fft_agu_seq: expected beats are queued at start and
// compared against every presented beat, including stalled ones.
module tb_fft_agu_seq;

  localparam int LOG2N_MAX = 5;
  localparam int STAGE_GAP = 2;
  localparam int TW_SCALE  = 1 << (LOG2N_MAX - 1);

  typedef struct {
    int a1;
    int a2;
    int tw;
    int st;
    bit last;
    bit conj;
    bit firstStage;
    bit firstRun;
    bit lastRun;
    int span;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] nLog2 = '0;
  logic       inverse = 1'b0;
  logic       ready = 1'b1;

  logic       valid, twiddleConj, lastInStage, busy, done, err;
  logic [4:0] address1, address2;
  logic [3:0] twiddleAddress;
  logic [2:0] stage;

  beat_t scoreQ[$];
  int    checks = 0;
  int    errors = 0;
  int    cycleCount = 0;
  int    firstValidCycle = 0;
  int    lastAcceptCycle = 0;
  int    readyMode = 0;
  bit    monEn = 1'b0;
  bit    expectDone = 1'b0;
  bit    prevValid = 1'b0;

  fft_agu_seq #(
    .LOG2N_MAX(LOG2N_MAX),
    .STAGE_GAP(STAGE_GAP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .n_log2         (nLog2),
    .inverse        (inverse),
    .ready          (ready),
    .valid          (valid),
    .address1       (address1),
    .address2       (address2),
    .twiddle_address(twiddleAddress),
    .twiddle_conj   (twiddleConj),
    .stage          (stage),
    .last_in_stage  (lastInStage),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  always @(posedge clk) begin
    #1;
    ready = (readyMode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", tag, got, want, $time);
    end
  endtask

  // Expected beats built group by group rather than from the pair index.
  task automatic pushRun(input int n, input bit inv, input int span);
    beat_t b;
    for (int s = 0; s < n; s++) begin
      int groups = (1 << n) >> (s + 1);
      int half   = 1 << s;
      for (int g = 0; g < groups; g++) begin
        for (int p = 0; p < half; p++) begin
          b.a1         = g * 2 * half + p;
          b.a2         = g * 2 * half + p + half;
          b.tw         = p * (TW_SCALE >> s);
          b.st         = s;
          b.last       = (g == groups - 1) && (p == half - 1);
          b.conj       = inv;
          b.firstStage = (g == 0) && (p == 0);
          b.firstRun   = b.firstStage && (s == 0);
          b.lastRun    = b.last && (s == n - 1);
          b.span       = span;
          scoreQ.push_back(b);
        end
      end
    end
  endtask

  task automatic applyStimulus(input int n, input bit inv, input int span);
    @(posedge clk); #1;
    start   = 1'b1;
    nLog2   = 3'(n);
    inverse = inv;
    pushRun(n, inv, span);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyBadStart(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    nLog2 = 3'(n);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("err_pulse", err, 1);
    checkOutput("busy_after_bad_start", busy, 0);
    @(posedge clk); #1;
    checkOutput("err_single_cycle", err, 0);
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    @(negedge clk); #1;
    while ((busy || scoreQ.size() != 0 || expectDone) && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("pending_at_idle", 32'(scoreQ.size()) + 32'(busy) + 32'(expectDone), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_conj"}, twiddleConj, 0);
    checkOutput({tag, "_last"}, lastInStage, 0);
    checkOutput({tag, "_addr1"}, address1, 0);
    checkOutput({tag, "_addr2"}, address2, 0);
    checkOutput({tag, "_twiddle"}, twiddleAddress, 0);
    checkOutput({tag, "_stage"}, stage, 0);
  endtask

  // Every presented beat, stalled or not, must match the queue head.
  always @(negedge clk) begin
    beat_t front;
    if (monEn && rst_n) begin
      checkOutput("done", done, expectDone);
      if (expectDone) begin
        checkOutput("busy_at_done", busy, 0);
        expectDone = 1'b0;
      end
      if (valid) begin
        if (scoreQ.size() == 0) begin
          checkOutput("unexpected_valid", valid, 0);
        end else begin
          front = scoreQ[0];
          if (!prevValid) begin
            if (front.firstRun) firstValidCycle = cycleCount;
            else if (front.firstStage)
              checkOutput("gap_len", cycleCount - lastAcceptCycle, STAGE_GAP + 1);
          end
          checkOutput("address1", address1, front.a1);
          checkOutput("address2", address2, front.a2);
          checkOutput("twiddle_address", twiddleAddress, front.tw);
          checkOutput("stage", stage, front.st);
          checkOutput("last_in_stage", lastInStage, front.last);
          checkOutput("twiddle_conj", twiddleConj, front.conj);
          checkOutput("busy_in_run", busy, 1);
          if (ready) begin
            void'(scoreQ.pop_front());
            lastAcceptCycle = cycleCount;
            if (front.lastRun) begin
              expectDone = 1'b1;
              if (front.span > 0)
                checkOutput("run_span", cycleCount - firstValidCycle + 1, front.span);
            end
          end
        end
      end
      prevValid = valid;
    end
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2 checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    monEn = 1'b1;

    $display("[TB] full 32-point forward run, ready high");
    applyStimulus(5, 1'b0, 80 + 4 * STAGE_GAP);
    waitIdle(400);

    $display("[TB] 8-point run");
    applyStimulus(3, 1'b0, 12 + 2 * STAGE_GAP);
    waitIdle(200);

    $display("[TB] illegal sizes");
    applyBadStart(0);
    applyBadStart(6);

    $display("[TB] inverse run with random ready");
    readyMode = 1;
    applyStimulus(5, 1'b1, 0);
    waitIdle(2000);
    readyMode = 0;

    $display("[TB] smallest transform");
    applyStimulus(1, 1'b0, 1);
    waitIdle(50);

    $display("[TB] start while busy is ignored");
    applyStimulus(4, 1'b0, 32 + 3 * STAGE_GAP);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    nLog2 = 3'd2;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("err_while_busy", err, 0);
    checkOutput("busy_while_busy", busy, 1);
    waitIdle(300);

    $display("[TB] reset in the middle of stage 2");
    applyStimulus(5, 1'b1, 0);
    n = 0;
    @(negedge clk); #1;
    while (!(valid && stage == 3'd2 && address1 == 5'd11) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("reached_stage2_pair7", address1, 11);
    rst_n      = 1'b0;
    monEn      = 1'b0;
    expectDone = 1'b0;
    prevValid  = 1'b0;
    scoreQ.delete();
    #1 checkAllZero("midrun_reset");
    repeat (2) begin
      @(negedge clk);
      checkOutput("done_during_reset", done, 0);
    end
    #2 rst_n = 1'b1;
    monEn = 1'b1;
    applyStimulus(3, 1'b0, 12 + 2 * STAGE_GAP);
    waitIdle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
